// File: rtl/conv_out_framer.sv
// Output FIFO for the 2D convolver: tags the last word of each frame, pulses frame completion.
// Optional sticky drop detection is enabled by defining CONV_FRAMER_OVERFLOW_EN.
module conv_out_framer #(
    parameter int NB_DATA     = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_WORDS = 9801,
    parameter int NB_LEVEL    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [NB_DATA-1:0]  i_data,
    output logic                o_ready,
    output logic                o_valid,
    output logic [NB_DATA-1:0]  o_data,
    output logic                o_last,
    input  logic                i_ready,
    output logic [NB_LEVEL-1:0] o_level,
    output logic                o_frame_done,
    output logic                o_overflow
);

    localparam int NB_PTR  = $clog2(FIFO_DEPTH);
    localparam int NB_WCNT = $clog2(FRAME_WORDS + 1);

    localparam logic [NB_LEVEL-1:0] LEVEL_FULL = NB_LEVEL'(FIFO_DEPTH);
    localparam logic [NB_WCNT-1:0]  WCNT_LAST  = NB_WCNT'(FRAME_WORDS - 1);

    logic [NB_DATA:0]    mem_r [FIFO_DEPTH];
    logic [NB_PTR-1:0]   wr_ptr_r;
    logic [NB_PTR-1:0]   rd_ptr_r;
    logic [NB_LEVEL-1:0] count_r;
    logic [NB_LEVEL-1:0] count_next_s;
    logic [NB_WCNT-1:0]  wcnt_r;
    logic                frame_done_r;
    logic                full_s;
    logic                empty_s;
    logic                wr_en_s;
    logic                rd_en_s;
    logic                tag_s;
    logic [NB_DATA:0]    head_s;

    assign full_s  = (count_r == LEVEL_FULL);
    assign empty_s = (count_r == {NB_LEVEL{1'b0}});
    assign wr_en_s = i_valid & ~full_s;
    assign rd_en_s = ~empty_s & i_ready;
    assign tag_s   = (wcnt_r == WCNT_LAST);
    assign head_s  = mem_r[rd_ptr_r];

    assign o_ready      = ~full_s;
    assign o_valid      = ~empty_s;
    assign o_data       = head_s[NB_DATA-1:0];
    assign o_last       = head_s[NB_DATA] & ~empty_s;
    assign o_level      = count_r;
    assign o_frame_done = frame_done_r;

    // Storage array; contents are intentionally left untouched by reset.
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= {tag_s, i_data};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Occupancy next-state: a simultaneous read and write leaves it unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_next_s = count_r + {{(NB_LEVEL-1){1'b0}}, 1'b1};
            2'b01:   count_next_s = count_r - {{(NB_LEVEL-1){1'b0}}, 1'b1};
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy and registered frame-done pulse.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_r     <= {NB_PTR{1'b0}};
            rd_ptr_r     <= {NB_PTR{1'b0}};
            count_r      <= {NB_LEVEL{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            count_r      <= count_next_s;
            frame_done_r <= rd_en_s & head_s[NB_DATA];
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{(NB_PTR-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + {{(NB_PTR-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Frame word position; only accepted words advance it, dropped words do not.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wcnt_r <= {NB_WCNT{1'b0}};
        end else if (wr_en_s) begin
            if (tag_s) begin
                wcnt_r <= {NB_WCNT{1'b0}};
            end else begin
                wcnt_r <= wcnt_r + {{(NB_WCNT-1){1'b0}}, 1'b1};
            end
        end else begin
            wcnt_r <= wcnt_r;
        end
    end

`ifdef CONV_FRAMER_OVERFLOW_EN
    logic overflow_r;

    // Sticky drop flag: the convolver does not honour ready, so valid while full is a lost word.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            overflow_r <= 1'b0;
        end else if (i_valid & full_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign o_overflow = overflow_r;
`else
    assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_conv_out_framer.sv
// Self-checking bench for conv_out_framer: directed scenarios plus random traffic
// checked against a queue-based reference model (FIFO_DEPTH=4, FRAME_WORDS=3).
module tb_conv_out_framer;

    localparam int NB_DATA     = 32;
    localparam int DEPTH       = 4;
    localparam int FW          = 3;
    localparam int NB_LEVEL    = $clog2(DEPTH) + 1;

    logic                i_clk = 1'b0;
    logic                i_reset;
    logic                i_valid;
    logic [NB_DATA-1:0]  i_data;
    logic                o_ready;
    logic                o_valid;
    logic [NB_DATA-1:0]  o_data;
    logic                o_last;
    logic                i_ready;
    logic [NB_LEVEL-1:0] o_level;
    logic                o_frame_done;
    logic                o_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [NB_DATA:0] q[$];
    int               acc_cnt;
    logic             fd_exp;
    logic             ov_exp;

    conv_out_framer #(
        .NB_DATA    (NB_DATA),
        .FIFO_DEPTH (DEPTH),
        .FRAME_WORDS(FW),
        .NB_LEVEL   (NB_LEVEL)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_last      (o_last),
        .i_ready     (i_ready),
        .o_level     (o_level),
        .o_frame_done(o_frame_done),
        .o_overflow  (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [NB_DATA-1:0] obs, input logic [NB_DATA-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [NB_DATA:0] head;
        chk({tag, ":level"}, 32'(o_level), 32'(q.size()));
        chk({tag, ":valid"}, 32'(o_valid), 32'(q.size() > 0));
        chk({tag, ":ready"}, 32'(o_ready), 32'(q.size() < DEPTH));
        chk({tag, ":frame_done"}, 32'(o_frame_done), 32'(fd_exp));
        chk({tag, ":overflow"}, 32'(o_overflow), 32'(ov_exp));
        if (q.size() > 0) begin
            head = q[0];
            chk({tag, ":data"}, o_data, head[NB_DATA-1:0]);
            chk({tag, ":last"}, 32'(o_last), 32'(head[NB_DATA]));
        end
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic cycle(input string tag, input logic v, input logic [NB_DATA-1:0] d, input logic r);
        bit               wr;
        bit               rd;
        logic             fd_next;
        logic [NB_DATA:0] head;
        i_valid = v;
        i_data  = d;
        i_ready = r;
        wr = v && (q.size() < DEPTH);
        rd = r && (q.size() > 0);
        fd_next = 1'b0;
        if (rd) begin
            head    = q.pop_front();
            fd_next = head[NB_DATA];
        end
`ifdef CONV_FRAMER_OVERFLOW_EN
        if (v && !wr) ov_exp = 1'b1;
`endif
        if (wr) begin
            q.push_back({((acc_cnt % FW) == FW - 1) ? 1'b1 : 1'b0, d});
            acc_cnt++;
        end
        @(posedge i_clk);
        fd_exp = fd_next;
        @(negedge i_clk);
        check_outputs(tag);
    endtask

    // Asynchronous reset assertion mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_reset = 1'b1;
        #1;
        chk("rst:valid", 32'(o_valid), 32'd0);
        chk("rst:level", 32'(o_level), 32'd0);
        chk("rst:ready", 32'(o_ready), 32'd1);
        chk("rst:last",  32'(o_last),  32'd0);
        q.delete();
        acc_cnt = 0;
        fd_exp  = 1'b0;
        ov_exp  = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b0;
        check_outputs("rst_rel");
    endtask

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = 32'h0;
        acc_cnt = 0;
        fd_exp  = 1'b0;
        ov_exp  = 1'b0;
        @(negedge i_clk);
        do_reset();

        // Streaming: 6 words at full rate, last tag on 0x33 and 0x66
        for (int i = 0; i < 6; i++) begin
            cycle("stream", 1'b1, 32'h11 * (i + 1), 1'b1);
        end
        for (int i = 0; i < 3; i++) cycle("stream_drain", 1'b0, 32'h0, 1'b1);

        // Reset with 2 words buffered mid-frame
        cycle("pre_rst", 1'b1, 32'hA1, 1'b0);
        cycle("pre_rst", 1'b1, 32'hA2, 1'b0);
        @(negedge i_clk);
        #2;
        do_reset();
        for (int i = 0; i < 4; i++) cycle("post_rst", 1'b1, 32'hB0 + 32'(i), 1'b1);
        for (int i = 0; i < 2; i++) cycle("post_rst_drain", 1'b0, 32'h0, 1'b1);

        // Fill, drop, full-with-read, drain
        for (int i = 0; i < 4; i++) cycle("fill", 1'b1, 32'hC1 + 32'(i), 1'b0);
        cycle("drop", 1'b1, 32'hDEAD, 1'b0);
        cycle("full_rd", 1'b1, 32'hBEEF, 1'b1);
        for (int i = 0; i < 4; i++) cycle("fill_drain", 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) cycle("after_drop", 1'b1, 32'hE0 + 32'(i), 1'b1);
        cycle("after_drop_drain", 1'b0, 32'h0, 1'b1);

        // Level held at 2 under simultaneous read/write, crossing pointer wrap
        do_reset();
        cycle("lvl2", 1'b1, 32'hF0, 1'b0);
        cycle("lvl2", 1'b1, 32'hF1, 1'b0);
        for (int i = 0; i < 10; i++) cycle("rw", 1'b1, 32'h100 + 32'(i), 1'b1);
        for (int i = 0; i < 3; i++) cycle("rw_drain", 1'b0, 32'h0, 1'b1);

        // Random traffic with occasional reset
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                @(negedge i_clk);
                #2;
                do_reset();
            end else begin
                cycle("rand", ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
